// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory transaction, load alignment and
// extension, stall generation, misalignment and bus-timeout flags.
module mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm2_regM,
  input  logic              we_dmM,
  input  logic [1:0]        size_dmM,
  input  logic              unsigned_dmM,
  input  logic [ADDR_W-1:0] alu_outM,
  input  logic [31:0]       wd_dmM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       rd_dmM,
  output logic              stallM,
  output logic              misalignM,
  output logic              buserrM
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic              req_q, we_q, mis_q, berr_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rd_q;
  // issued copies used for load extraction
  logic              ld_q, uns_q;
  logic [1:0]        sz_q, lane_q;

  logic        active, misal, go, tmo;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, ld_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign active = dm2_regM | we_dmM;
  assign tmo    = (cnt_q == CW'(TIMEOUT));
  assign go     = (state_q == S_IDLE) && active && !misal;

  // misalignment, byte enables and lane-replicated write data for the request
  always_comb begin
    misal   = 1'b0;
    be_n    = 4'b1111;
    wdata_n = wd_dmM;
    case (size_dmM)
      2'b00: begin
        be_n    = 4'b0001 << alu_outM[1:0];
        wdata_n = {4{wd_dmM[7:0]}};
      end
      2'b01: begin
        misal   = alu_outM[0];
        be_n    = 4'b0011 << alu_outM[1:0];
        wdata_n = {2{wd_dmM[15:0]}};
      end
      default: misal = (alu_outM[1:0] != 2'b00);
    endcase
  end

  // pick the addressed lane out of the returned word and extend it
  always_comb begin
    ld_b = mem_rdata[7:0];
    case (lane_q)
      2'd1:    ld_b = mem_rdata[15:8];
      2'd2:    ld_b = mem_rdata[23:16];
      2'd3:    ld_b = mem_rdata[31:24];
      default: ld_b = mem_rdata[7:0];
    endcase
    ld_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (sz_q)
      2'b00:   ld_data = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_WAIT;
      S_WAIT:  if (mem_ack || tmo) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall while issuing and while waiting
  always_comb begin
    stallM = go || (state_q == S_WAIT);
  end

  // bus registers, wait counter, load result and one-cycle flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      ld_q    <= 1'b0;
      uns_q   <= 1'b0;
      sz_q    <= 2'b00;
      lane_q  <= 2'b00;
    end else begin
      mis_q  <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (active && misal) begin
            mis_q <= 1'b1;
            if (!we_dmM) rd_q <= '0;
          end else if (active) begin
            req_q   <= 1'b1;
            we_q    <= we_dmM;
            be_q    <= be_n;
            addr_q  <= {alu_outM[ADDR_W-1:2], 2'b00};
            wdata_q <= wdata_n;
            cnt_q   <= '0;
            ld_q    <= ~we_dmM;
            uns_q   <= unsigned_dmM;
            sz_q    <= size_dmM;
            lane_q  <= alu_outM[1:0];
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (ld_q) rd_q <= ld_data;
          end else if (tmo) begin
            req_q  <= 1'b0;
            rd_q   <= '0;
            berr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rd_dmM    = rd_q;
  assign misalignM = mis_q;
  assign buserrM   = berr_q;
endmodule
